// File: rtl/pim_pkg.sv
// Shared definitions for the PIM weight-loader path: element width, FSM encoding, clogb2.
package pim_pkg;

    localparam int INPUT_BIT_DEFAULT = 6;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PACK  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_PACK  = S_PACK,
        ST_WRITE = S_WRITE,
        ST_WAIT  = S_WAIT,
        ST_DONE  = S_DONE
    } state_t;

    // Ceiling log2, never below 1 so counters always have at least one bit.
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pim_row_packer.sv
// Packs VEC_LEN serial elements into one row word, first element in the MSB slot.
// One element per load cycle; row_full flags the load of the last slot.
module pim_row_packer
    import pim_pkg::*;
#(
    parameter int INPUT_BIT = INPUT_BIT_DEFAULT,
    parameter int VEC_LEN   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           load,
    input  logic [INPUT_BIT-1:0]           elem,
    output logic [INPUT_BIT*VEC_LEN-1:0]   row_word,
    output logic                           row_full
);

    localparam int CW = clogb2(VEC_LEN);

    logic [CW-1:0] cnt;

    assign row_full = load && (cnt == CW'(VEC_LEN - 1));

    // Slots are overwritten in place, so the previous row stays visible until repacked.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            row_word <= '0;
        end else begin
            if (clear || row_full) begin
                cnt <= '0;
            end else if (load) begin
                cnt <= cnt + CW'(1);
            end
            if (load) begin
                for (int k = 0; k < VEC_LEN; k++) begin
                    if (cnt == CW'(k)) row_word[(VEC_LEN-1-k)*INPUT_BIT +: INPUT_BIT] <= elem;
                end
            end
        end
    end

endmodule

// File: rtl/pim_weight_loader.sv
// Programs ROWS crossbar rows from a valid/ready element stream, honouring WR_LAT idle cycles per write.
// elem_ready is high only while packing; PIM_WLOAD_CHECKSUM_EN adds a signed running-sum output.
module pim_weight_loader
    import pim_pkg::*;
#(
    parameter int INPUT_BIT = INPUT_BIT_DEFAULT,
    parameter int VEC_LEN   = 32,
    parameter int DEPTH     = 1,
    parameter int ROWS      = 2,
    parameter int WR_LAT    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [INPUT_BIT-1:0]         elem_in,
    input  logic                         elem_valid,
    output logic                         elem_ready,
    output logic [INPUT_BIT*VEC_LEN-1:0] wr_data,
    output logic [DEPTH-1:0]             wr_addr,
    output logic                         wr_en,
    output logic                         busy,
    output logic                         done
`ifdef PIM_WLOAD_CHECKSUM_EN
    ,
    output logic signed [INPUT_BIT+clogb2(VEC_LEN*ROWS):0] checksum
`endif
);

    localparam int LW = clogb2(WR_LAT + 1);

    state_t           state;
    logic [DEPTH-1:0] row;
    logic [LW-1:0]    lat;
    logic             xfer;
    logic             row_full;
    logic             accept_start;
    logic             last_row;

    assign elem_ready   = (state == ST_PACK);
    assign xfer         = elem_valid && elem_ready;
    assign accept_start = (state == ST_IDLE) && start;
    assign last_row     = (row == DEPTH'(ROWS - 1));

    pim_row_packer #(
        .INPUT_BIT (INPUT_BIT),
        .VEC_LEN   (VEC_LEN)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept_start),
        .load     (xfer),
        .elem     (elem_in),
        .row_word (wr_data),
        .row_full (row_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            row     <= '0;
            lat     <= '0;
            wr_addr <= '0;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_PACK;
                        busy  <= 1'b1;
                        row   <= '0;
                    end
                end
                ST_PACK: begin
                    if (row_full) begin
                        state   <= ST_WRITE;
                        wr_en   <= 1'b1;
                        wr_addr <= row;
                    end
                end
                ST_WRITE: begin
                    if (WR_LAT > 0) begin
                        state <= ST_WAIT;
                        lat   <= '0;
                    end else if (last_row) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_PACK;
                        row   <= row + DEPTH'(1);
                    end
                end
                ST_WAIT: begin
                    if (lat != LW'(WR_LAT - 1)) begin
                        lat <= lat + LW'(1);
                    end else if (last_row) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_PACK;
                        row   <= row + DEPTH'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIM_WLOAD_CHECKSUM_EN
    localparam int CSW = INPUT_BIT + clogb2(VEC_LEN * ROWS) + 1;

    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + {{(CSW-INPUT_BIT){elem_in[INPUT_BIT-1]}}, elem_in};
        end
    end
`endif

endmodule

// File: tb/tb_pim_weight_loader.sv
// Drives two loaders (WR_LAT=2 and WR_LAT=0) from one element stream and checks them against a row model.
module tb_pim_weight_loader;

    localparam int IB  = 6;
    localparam int VL  = 32;
    localparam int RW  = 2;
    localparam int W   = IB * VL;
    localparam int CSW = IB + 6 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          sel = 1'b0;
    logic          start_a = 1'b0, start_b = 1'b0;
    logic          elem_valid = 1'b0;
    logic [IB-1:0] elem_in = '0;
    logic          rdy_a, rdy_b, wr_a, wr_b, busy_a, busy_b, done_a, done_b;
    logic [W-1:0]  data_a, data_b;
    logic [0:0]    addr_a, addr_b;
`ifdef PIM_WLOAD_CHECKSUM_EN
    logic signed [CSW-1:0] cs_a, cs_b;
`endif

    pim_weight_loader #(.INPUT_BIT(IB), .VEC_LEN(VL), .DEPTH(1), .ROWS(RW), .WR_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .elem_in(elem_in), .elem_valid(elem_valid),
        .elem_ready(rdy_a), .wr_data(data_a), .wr_addr(addr_a), .wr_en(wr_a), .busy(busy_a), .done(done_a)
`ifdef PIM_WLOAD_CHECKSUM_EN
        , .checksum(cs_a)
`endif
    );

    pim_weight_loader #(.INPUT_BIT(IB), .VEC_LEN(VL), .DEPTH(1), .ROWS(RW), .WR_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .elem_in(elem_in), .elem_valid(elem_valid),
        .elem_ready(rdy_b), .wr_data(data_b), .wr_addr(addr_b), .wr_en(wr_b), .busy(busy_b), .done(done_b)
`ifdef PIM_WLOAD_CHECKSUM_EN
        , .checksum(cs_b)
`endif
    );

    logic         cur_rdy, cur_wr, cur_busy, cur_done;
    logic [W-1:0] cur_data;
    logic [0:0]   cur_addr;
    assign cur_rdy  = sel ? rdy_b  : rdy_a;
    assign cur_wr   = sel ? wr_b   : wr_a;
    assign cur_busy = sel ? busy_b : busy_a;
    assign cur_done = sel ? done_b : done_a;
    assign cur_data = sel ? data_b : data_a;
    assign cur_addr = sel ? addr_b : addr_a;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_seen = 0;

    logic [0:0]   obs_addr[$];
    logic [W-1:0] obs_data[$];
    bit           obs_rdy_at[$];
    bit           obs_rdy_after[$];
    bit           prev_wr = 1'b0;

    always @(posedge clk) cyc++;

    // Passive capture of every write strobe and done pulse from the selected loader.
    always @(negedge clk) begin
        if (prev_wr) obs_rdy_after.push_back(cur_rdy);
        prev_wr = cur_wr;
        if (cur_wr) begin
            obs_addr.push_back(cur_addr);
            obs_data.push_back(cur_data);
            obs_rdy_at.push_back(cur_rdy);
        end
        if (cur_done) done_seen++;
    end

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_rdy_at.delete();
        obs_rdy_after.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done_a); end
        total++; if (wr_a !== 1'b0) begin bad++; $display("FAIL reset_wr_en got %b want 0", wr_a); end
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", rdy_a); end
        total++; if (addr_a !== 1'b0) begin bad++; $display("FAIL reset_addr got %h want 0", addr_a); end
        total++; if (data_a !== '0) begin bad++; $display("FAIL reset_data got %h want 0", data_a); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // mode 0: random, 1: ascending 0..63, 2: alternating -32/31
    task automatic run_load(input bit b, input int mode, input int stall_len, input bit ghost, input string name);
        logic [IB-1:0] elems[RW*VL];
        logic [W-1:0]  w;
        int idx = 0, stalls = 0, guard = 0, start_edge, done_edge, d0, lat, sum = 0;
        lat = b ? 0 : 2;
        for (int i = 0; i < RW*VL; i++) begin
            case (mode)
                1:       elems[i] = IB'(i);
                2:       elems[i] = (i % 2 == 0) ? 6'b100000 : 6'd31;
                default: elems[i] = IB'($urandom);
            endcase
            sum += int'($signed(elems[i]));
        end
        clear_obs();
        d0 = done_seen;
        @(negedge clk);
        sel = b;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        elem_valid = 1'b1;
        elem_in = IB'($urandom);
        start_edge = cyc + 1;
        @(negedge clk);
        while (idx < RW*VL && guard < 3000) begin
            guard++;
            if (b) start_b = ghost && (idx == 5); else start_a = ghost && (idx == 5);
            if (cur_rdy && stall_len > 0 && idx == 11 && stalls < stall_len) begin
                elem_valid = 1'b0;
                stalls++;
            end else if (cur_rdy) begin
                elem_valid = 1'b1;
                elem_in = elems[idx];
                idx++;
            end else begin
                elem_valid = 1'b1;
                elem_in = IB'($urandom);
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        elem_valid = 1'b1;
        elem_in = IB'($urandom);
        while (!cur_done && guard < 3000) begin
            guard++;
            elem_in = IB'($urandom);
            @(negedge clk);
        end
        done_edge = cyc;
        total++;
        if (!cur_done) begin bad++; $display("FAIL %s done_timeout got no done want done", name); end
`ifdef PIM_WLOAD_CHECKSUM_EN
        total++;
        if ((b ? cs_b : cs_a) !== CSW'(sum)) begin
            bad++; $display("FAIL %s checksum got %0d want %0d", name, b ? cs_b : cs_a, sum);
        end
`endif
        total++;
        if (done_edge - start_edge !== RW*(VL+1+lat) + stall_len) begin
            bad++; $display("FAIL %s done_latency got %0d want %0d", name, done_edge - start_edge, RW*(VL+1+lat) + stall_len);
        end
        total++;
        if (obs_addr.size() !== RW) begin bad++; $display("FAIL %s write_count got %0d want %0d", name, obs_addr.size(), RW); end
        for (int r = 0; r < RW && r < obs_addr.size(); r++) begin
            w = '0;
            for (int k = 0; k < VL; k++) w = {w[W-IB-1:0], elems[r*VL+k]};
            total++;
            if (obs_addr[r] !== 1'(r)) begin bad++; $display("FAIL %s row%0d addr got %0d want %0d", name, r, obs_addr[r], r); end
            total++;
            if (obs_data[r] !== w) begin bad++; $display("FAIL %s row%0d data got %h want %h", name, r, obs_data[r], w); end
            total++;
            if (obs_rdy_at[r] !== 1'b0) begin bad++; $display("FAIL %s row%0d ready_in_write got 1 want 0", name, r); end
            if (b && r < RW-1 && r < obs_rdy_after.size()) begin
                total++;
                if (obs_rdy_after[r] !== 1'b1) begin bad++; $display("FAIL %s row%0d ready_after_write got 0 want 1", name, r); end
            end
        end
        elem_valid = 1'b0;
        @(negedge clk);
        total++;
        if (cur_busy !== 1'b0 || cur_done !== 1'b0) begin
            bad++; $display("FAIL %s post_done busy=%b done=%b want 0 0", name, cur_busy, cur_done);
        end
        total++;
        if (done_seen - d0 !== 1) begin bad++; $display("FAIL %s done_pulses got %0d want 1", name, done_seen - d0); end
    endtask

    task automatic test_reset_mid();
        int idx = 0, guard = 0, d0;
        clear_obs();
        d0 = done_seen;
        @(negedge clk);
        sel = 1'b0;
        start_a = 1'b1;
        elem_valid = 1'b1;
        elem_in = IB'($urandom);
        @(negedge clk);
        start_a = 1'b0;
        while (idx < 20 && guard < 200) begin
            guard++;
            if (cur_rdy) idx++;
            elem_in = IB'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy_a !== 1'b0 || rdy_a !== 1'b0 || wr_a !== 1'b0 || done_a !== 1'b0) begin
            bad++; $display("FAIL rst_mid outputs busy=%b ready=%b wr_en=%b done=%b want 0 0 0 0", busy_a, rdy_a, wr_a, done_a);
        end
        rst = 1'b0;
        repeat (100) begin
            elem_in = IB'($urandom);
            @(negedge clk);
        end
        elem_valid = 1'b0;
        total++;
        if (obs_addr.size() !== 0) begin bad++; $display("FAIL rst_mid writes got %0d want 0", obs_addr.size()); end
        total++;
        if (done_seen !== d0) begin bad++; $display("FAIL rst_mid done_pulses got %0d want 0", done_seen - d0); end
    endtask

    task automatic test_basic();       run_load(1'b0, 1, 0, 1'b0, "basic");     endtask
    task automatic test_stall();       run_load(1'b0, 0, 5, 1'b0, "stall");     endtask
    task automatic test_signed();      run_load(1'b0, 2, 0, 1'b0, "signed");    endtask
    task automatic test_start_busy();  run_load(1'b0, 0, 0, 1'b1, "start_busy"); endtask
    task automatic test_wr_lat0();     run_load(1'b1, 0, 0, 1'b1, "wr_lat0");   endtask
    task automatic test_back_to_back();
        run_load(1'b0, 0, 0, 1'b0, "b2b_first");
        run_load(1'b0, 0, 0, 1'b0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_signed();
        test_reset_mid();
        run_load(1'b0, 0, 0, 1'b0, "after_rst");
        test_start_busy();
        test_wr_lat0();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
